// File: rtl/varredor_mux_4_1.sv
// Select sequencer and sampler for a 4:1 mux: steps s1/s0 over the enabled channels,
// waits a settle time per channel, captures y, and pulses valid once per scan frame.
module varredor_mux_4_1 #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic [3:0] ch_mask,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] amostras,
  output logic       valid,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_settle
      $error("varredor_mux_4_1: SETTLE_CYCLES=%0d outside 1..2^CNT_W-1", SETTLE_CYCLES);
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       amostras_q, amostras_d;

  // Returns {found, channel}: lowest enabled channel with index >= from.
  function automatic logic [2:0] first_enabled(input logic [3:0] m, input int from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= from) begin
        res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  logic [2:0] launch_pick;
  logic [2:0] next_pick;

  assign launch_pick = first_enabled(ch_mask, 0);
  assign next_pick   = first_enabled(mask_q, int'(sel_q) + 1);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    amostras_d = amostras_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = ch_mask;
          if (launch_pick[2]) begin
            sel_d   = launch_pick[1:0];
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          amostras_d[sel_q] = y;
          if (next_pick[2]) begin
            sel_d = next_pick[1:0];
            cnt_d = SETTLE_LD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Continuous mode relaunches exactly as a start from IDLE would.
        if (continuous) begin
          mask_d = ch_mask;
          if (launch_pick[2]) begin
            sel_d   = launch_pick[1:0];
            cnt_d   = SETTLE_LD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'b00;
      cnt_q      <= '0;
      mask_q     <= 4'b0000;
      amostras_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      amostras_q <= amostras_d;
    end
  end

  assign s1       = sel_q[1];
  assign s0       = sel_q[0];
  assign amostras = amostras_q;
  assign valid    = (state_q == ST_DONE);
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/varredor_mux_4_1.md
Name: varredor_mux_4_1

Overview:
- Upstream select sequencer and sampler for the 4:1 multiplexer (multiplexador_4_1).
- Drives the mux select lines s1/s0 round-robin over the enabled channels.
- After each select change it waits a programmable settle time, then captures the mux output y into a per-channel sample register.
- Reports each complete scan frame with a one-cycle valid pulse. Runs single-shot or continuously.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between a select change and the sampling of y; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the settle counter.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a frame when the block is idle; ignored while busy=1.
- continuous  in  1  when 1 at frame end, the next frame starts immediately.
- ch_mask  in  4  channel enables; bit i enables channel i (select value i). Latched at frame start.
- y  in  1  output of the 4:1 mux being scanned.
- s1  out  1  mux select MSB.
- s0  out  1  mux select LSB.
- amostras  out  4  bit i holds the last sampled y for channel i.
- valid  out  1  one-cycle pulse; frame complete, amostras stable.
- busy  out  1  high in SETTLE and DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; {s1,s0}=00; amostras=0000; valid=0; busy=0; counter=0; latched mask=0000.
  - Reset has priority over every other input.
  - Reset mid-frame aborts the frame; no valid pulse is produced.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - Outputs hold. {s1,s0} keeps its last value.
  - On start=1: latch ch_mask.
  - If the mask is nonzero: {s1,s0} <= lowest enabled channel; counter <= SETTLE_CYCLES; go to SETTLE.
  - If the mask is 0000: go to DONE. Nothing is sampled and {s1,s0} is unchanged.
- SETTLE:
  - Counter decrements each edge.
  - On the edge where counter==1: amostras[{s1,s0}] <= y.
  - If a higher-numbered enabled channel remains: {s1,s0} <= next enabled channel (ascending, no wrap within a frame); counter <= SETTLE_CYCLES; stay in SETTLE.
  - Otherwise go to DONE.
  - Each enabled channel therefore occupies exactly SETTLE_CYCLES cycles. y is sampled at the SETTLE_CYCLES-th edge after the select update.
- DONE:
  - valid=1 for exactly this cycle.
  - If continuous=1: re-latch ch_mask and restart as from IDLE with start=1, including the 0000-mask case.
  - If continuous=0: go to IDLE.
- Latency: with N enabled channels (N≥1) and start sampled at edge E0, valid is high during the cycle after edge E0+N·SETTLE_CYCLES. Back-to-back frame period is N·SETTLE_CYCLES+1 cycles. With a 0000 mask, valid is high in the cycle after E0.
- Masked channels: never selected; their amostras bits retain prior values.
- start:
  - Ignored in SETTLE and DONE; it is not queued.
  - start held high in IDLE begins a frame on the first edge.
- ch_mask changes mid-frame have no effect until the next latch.
- busy=0 only in IDLE.
- SETTLE_CYCLES=0 is illegal; a simulation-time check flags it.

Test Plan:
1. Assert rst for 2 cycles mid-operation -> s1 s0=00, amostras=0000, valid=0, busy=0 on the next cycle; no valid pulse later.
2. SETTLE_CYCLES=2, mux constants d0..d3=0,1,0,1 feeding y, ch_mask=1111, pulse start -> select sequence 00,01,10,11 held 2 cycles each; valid high in the 9th cycle after the start edge; amostras=1010.
3. Preload amostras=1010, set d0..d3=1,1,1,1, ch_mask=0101 -> only 00 then 10 selected; valid after 4+1 cycles; amostras=1111 (bits 1 and 3 retain 1).
4. ch_mask=0000, pulse start -> valid on the next cycle, s1 s0 unchanged, amostras unchanged.
5. continuous=1, ch_mask=1111, SETTLE_CYCLES=2 -> valid every 9 cycles. Toggle d2 between frames -> amostras[2] follows. Drop continuous -> IDLE after the current frame; busy=0.
6. Pulse start while busy=1 -> no restart, frame timing unchanged. Change ch_mask mid-frame -> current frame uses the originally latched mask.
